dcache_ctrl: RTL and testbench

Data-cache responder serving the memory-side end of the core's data port. It accepts the core's per-cycle address, read-enable and byte-write-enable, and returns load data one cycle later. It raises `stall` to freeze the whole pipeline on read misses and on stores the backing memory cannot yet accept. The cache is direct-mapped, write-through and no-write-allocate, with one-word lines, and is backed by a valid/ready word-wide memory port.

---
 rtl/dcache_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// with one-word lines. Serves the core's data port with one-cycle load
// latency and raises stall on read misses and on stores the backing memory
// has not yet accepted.
module dcache_ctrl #(
   parameter int LINES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] dcache_addr,
   input  logic        dcache_re,
   input  logic [3:0]  dcache_we,
   input  logic [31:0] dcache_din,
   output logic [31:0] dcache_dout,
   output logic        stall,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_rw,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_data,
   output logic [3:0]  mem_req_mask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data
);

   localparam int IDX = $clog2(LINES);
   localparam int TAG = 30 - IDX;

   typedef enum logic [1:0] {
      LOOKUP    = 2'd0,
      MISS_REQ  = 2'd1,
      MISS_WAIT = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Request register: the access captured on the last non-stalled edge.
   logic        req_valid;
   logic [29:0] req_waddr;
   logic [3:0]  req_we;
   logic [31:0] req_din;

   // Line storage.
   logic [LINES-1:0] valid_q;
   logic [TAG-1:0]   tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   logic [IDX-1:0] req_idx;
   logic [TAG-1:0] req_tag;
   logic           req_store;
   logic           hit;
   logic           fill;
   logic           store_wr;

   // The byte offset is irrelevant for word-wide lines.
   logic unused_addr_lo;
   assign unused_addr_lo = ^dcache_addr[1:0];

   assign req_idx   = req_waddr[IDX-1:0];
   assign req_tag   = req_waddr[29:IDX];
   assign req_store = (req_we != 4'b0000);
   assign hit       = req_valid && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   // A fill completes on the response; a store updates the line only if it
   // already holds the addressed word and memory accepts the write.
   assign fill     = (state == MISS_WAIT) && mem_resp_valid;
   assign store_wr = (state == LOOKUP) && req_valid && req_store && mem_req_ready && hit;

   // Capture a new core request whenever the pipeline is not frozen.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; combinational blocks below use blocking (=).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_valid <= 1'b0;
         req_waddr <= '0;
         req_we    <= 4'b0000;
         req_din   <= '0;
      end else if (!stall) begin
         req_valid <= dcache_re || (dcache_we != 4'b0000);
         req_waddr <= dcache_addr[31:2];
         req_we    <= dcache_we;
         req_din   <= dcache_din;
      end
   end

   // Valid bits: cleared by reset, set by a completed fill.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
      end else if (fill) begin
         valid_q[req_idx] <= 1'b1;
      end
   end

   // Tag and data arrays: written by fills and by store hits.
   // NOTE: tags and data carry no reset; a line is meaningless until its
   // valid bit is set, so resetting the arrays would only add logic.
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_q[req_idx]  <= req_tag;
         data_q[req_idx] <= mem_resp_data;
      end else if (store_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (req_we[b]) begin
               data_q[req_idx][8*b +: 8] <= req_din[8*b +: 8];
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= LOOKUP;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: a read miss requests the line, then waits for it.
   always_comb begin
      state_nxt = state;
      case (state)
         LOOKUP: begin
            if (req_valid && !req_store && !hit) begin
               state_nxt = mem_req_ready ? MISS_WAIT : MISS_REQ;
            end
         end
         MISS_REQ: begin
            if (mem_req_ready) begin
               state_nxt = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            if (mem_resp_valid) begin
               state_nxt = LOOKUP;
            end
         end
         default: state_nxt = LOOKUP;
      endcase
   end

   // Output logic: stall, memory request handshake and load data.
   // NOTE: every output gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      stall         = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_rw    = 1'b0;
      dcache_dout   = '0;
      case (state)
         LOOKUP: begin
            if (req_valid) begin
               if (req_store) begin
                  mem_req_valid = 1'b1;
                  mem_req_rw    = 1'b1;
                  stall         = !mem_req_ready;
               end else if (hit) begin
                  dcache_dout = data_q[req_idx];
               end else begin
                  stall         = 1'b1;
                  mem_req_valid = 1'b1;
               end
            end
         end
         MISS_REQ: begin
            stall         = 1'b1;
            mem_req_valid = 1'b1;
         end
         MISS_WAIT: begin
            stall = 1'b1;
         end
         default: ;
      endcase
   end

   // Request fields come straight from the held request, so they stay
   // stable for as long as the handshake is pending.
   assign mem_req_addr = {req_waddr, 2'b00};
   assign mem_req_data = req_din;
   assign mem_req_mask = mem_req_rw ? req_we : 4'b0000;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and randomized accesses against a reference model
// consisting of a word-addressed backing memory and a per-index record of
// which word address each cache line currently holds.
module tb_dcache_ctrl;

   localparam int LINES = 64;
   localparam int LIDX  = $clog2(LINES);

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] dcache_addr;
   logic        dcache_re;
   logic [3:0]  dcache_we;
   logic [31:0] dcache_din;
   logic [31:0] dcache_dout;
   logic        stall;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_rw;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_data;
   logic [3:0]  mem_req_mask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   int checks = 0;
   int errors = 0;

   // Reference model.
   logic [31:0] mem_model [logic [29:0]];
   bit          line_vld  [LINES];
   logic [29:0] line_wa   [LINES];

   dcache_ctrl #(.LINES(LINES)) dut (
      .clk           (clk),
      .reset         (reset),
      .dcache_addr   (dcache_addr),
      .dcache_re     (dcache_re),
      .dcache_we     (dcache_we),
      .dcache_din    (dcache_din),
      .dcache_dout   (dcache_dout),
      .stall         (stall),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_rw    (mem_req_rw),
      .mem_req_addr  (mem_req_addr),
      .mem_req_data  (mem_req_data),
      .mem_req_mask  (mem_req_mask),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_data (mem_resp_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [29:0] wa);
      if (!mem_model.exists(wa)) mem_model[wa] = $urandom;
      return mem_model[wa];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < LINES; i++) line_vld[i] = 1'b0;
   endtask

   // One core access: presented now (caller is between edges with stall low),
   // captured on the next edge; rwait cycles of ready low before acceptance,
   // read response k cycles after acceptance.
   task automatic access(input logic [31:0] addr, input logic [3:0] we,
                         input logic [31:0] din, input int rwait, input int k,
                         input string tag, output logic [31:0] obs_dout);
      logic [29:0] wa;
      int          idx;
      bit          is_store, is_hit, done;
      int          exp_stall, exp_reqs, stall_cnt, req_cnt, acc_cyc;
      logic [31:0] rd, exp_dout, merged;
      logic [1:0]  lo;
      wa        = addr[31:2];
      idx       = int'(wa % LINES);
      is_store  = (we != 4'b0000);
      is_hit    = line_vld[idx] && (line_wa[idx] == wa);
      rd        = mem_rd(wa);
      stall_cnt = 0;
      req_cnt   = 0;
      acc_cyc   = -1;
      done      = 1'b0;
      if (is_store) begin
         exp_stall = rwait; exp_reqs = 1; exp_dout = 32'h0;
      end else if (is_hit) begin
         exp_stall = 0;     exp_reqs = 0; exp_dout = rd;
      end else begin
         exp_stall = rwait + 1 + k; exp_reqs = 1; exp_dout = rd;
      end

      lo          = 2'($urandom_range(3, 0));
      dcache_addr = {addr[31:2], lo};
      dcache_re   = is_store ? 1'($urandom_range(1, 0)) : 1'b1;
      dcache_we   = we;
      dcache_din  = din;
      @(posedge clk); #1;
      dcache_re   = 1'b0;
      dcache_we   = 4'b0000;
      dcache_addr = $urandom;
      dcache_din  = $urandom;

      for (int c = 0; c < 40 && !done; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         mem_req_ready  = (c >= rwait);
         mem_resp_valid = (acc_cyc >= 0) && (c == acc_cyc + k);
         mem_resp_data  = mem_resp_valid ? rd : $urandom;
         @(negedge clk);
         if (mem_req_valid) begin
            check({tag, " req_addr"}, mem_req_addr, {wa, 2'b00});
            check({tag, " req_rw"},   32'(mem_req_rw), 32'(is_store));
            check({tag, " req_mask"}, 32'(mem_req_mask), is_store ? 32'(we) : 32'h0);
            if (is_store) check({tag, " req_data"}, mem_req_data, din);
            if (mem_req_ready) begin
               req_cnt++;
               acc_cyc = c;
            end
         end
         if (stall) stall_cnt++;
         else done = 1'b1;
      end
      check({tag, " completes"},    32'(done), 32'h1);
      check({tag, " stall_cycles"}, stall_cnt, exp_stall);
      check({tag, " mem_requests"}, req_cnt, exp_reqs);
      check({tag, " dout"},         dcache_dout, exp_dout);
      obs_dout = dcache_dout;

      if (is_store) begin
         merged = rd;
         for (int b = 0; b < 4; b++) if (we[b]) merged[8*b +: 8] = din[8*b +: 8];
         mem_model[wa] = merged;
      end else if (!is_hit) begin
         line_vld[idx] = 1'b1;
         line_wa[idx]  = wa;
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [29:0] wa;
      logic [3:0]  we;
      reset          = 1'b0;
      dcache_addr    = '0;
      dcache_re      = 1'b0;
      dcache_we      = 4'b0000;
      dcache_din     = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      model_clear();

      #1;
      check("reset stall",     32'(stall), 32'h0);
      check("reset req_valid", 32'(mem_req_valid), 32'h0);
      check("reset dout",      dcache_dout, 32'h0);
      check("reset mask",      32'(mem_req_mask), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Read miss, then hit.
      mem_model[30'h04000004] = 32'hDEADBEEF;
      access(32'h10000010, 4'b0000, 32'h0, 0, 3, "miss1", d);
      check("miss1 value", d, 32'hDEADBEEF);
      access(32'h10000010, 4'b0000, 32'h0, 0, 1, "hit1", d);
      check("hit1 value", d, 32'hDEADBEEF);

      // Byte store hit, then read the merged word.
      access(32'h10000010, 4'b0010, 32'h0000AA00, 0, 1, "st_hit", d);
      access(32'h10000010, 4'b0000, 32'h0, 0, 1, "hit2", d);
      check("merge value", d, 32'hDEADAAEF);

      // Store miss under backpressure; no allocation afterwards.
      access(32'h20000020, 4'b1111, 32'h12345678, 2, 1, "st_miss", d);
      access(32'h20000020, 4'b0000, 32'h0, 0, 2, "no_alloc", d);
      check("no_alloc value", d, 32'h12345678);

      // Conflicting tags on the same index.
      for (int i = 0; i < 3; i++) begin
         access(32'h00000004, 4'b0000, 32'h0, i % 2, 1 + i, "conf_a", d);
         access(32'h00000104, 4'b0000, 32'h0, 0, 2, "conf_b", d);
      end

      // Randomized accesses over a small, conflict-heavy address pool.
      for (int n = 0; n < 80; n++) begin
         wa = (30'($urandom_range(2, 0)) << LIDX) | 30'($urandom_range(3, 0));
         we = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 1)) : 4'b0000;
         access({wa, 2'b00}, we, $urandom, $urandom_range(2, 0),
                $urandom_range(3, 1), "rand", d);
      end

      // Reset while waiting for a fill response.
      dcache_addr = 32'h30000040;
      dcache_re   = 1'b1;
      dcache_we   = 4'b0000;
      @(posedge clk); #1;
      dcache_re      = 1'b0;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      @(negedge clk);
      check("rstw lookup stall", 32'(stall), 32'h1);
      check("rstw lookup valid", 32'(mem_req_valid), 32'h1);
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      @(negedge clk);
      check("rstw wait stall", 32'(stall), 32'h1);
      check("rstw wait valid", 32'(mem_req_valid), 32'h0);
      #2;
      reset = 1'b0;
      #1;
      check("rstw async stall", 32'(stall), 32'h0);
      check("rstw async valid", 32'(mem_req_valid), 32'h0);
      check("rstw async dout",  dcache_dout, 32'h0);
      check("rstw async mask",  32'(mem_req_mask), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      model_clear();
      @(posedge clk); #1;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hBAD0BAD0;
      @(negedge clk);
      check("late resp stall", 32'(stall), 32'h0);
      check("late resp valid", 32'(mem_req_valid), 32'h0);
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      @(negedge clk);
      access(32'h10000010, 4'b0000, 32'h0, 0, 2, "post_rst", d);
      access(32'h30000040, 4'b0000, 32'h0, 1, 1, "post_rst2", d);
      access(32'h10000010, 4'b0000, 32'h0, 0, 1, "post_rst_hit", d);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
